wwl_ctrl: RTL and testbench
===========================

Name: wwl_ctrl

Overview:
Write-side counterpart of the read word-line buffer stripe for the latch-based standard-cell memory array. It accepts one write request at a time over a valid/ready handshake and registers the address and data. It then drives the shared write bit lines and fires a one-hot write word line (WWL) pulse whose timing is safe for latch capture: data setup, pulse, then data hold. It sits between the memory's write interface and the array's 2**ADDR_WIDTH word-line drivers.

Parameters:
ADDR_WIDTH, 3, word address width; the array has 2**ADDR_WIDTH rows (8 by default).
DATA_WIDTH, 8, word width in bits.
PULSE_CYCLES, 1, number of cycles WWL stays asserted; legal range 1..15.

Ports:
CLK  in  1  single clock; all state updates on the rising edge.
RST_N  in  1  synchronous reset, active-low.
WR_VALID  in  1  write request valid.
WR_READY  out  1  controller can accept a request.
WR_ADDR  in  ADDR_WIDTH  row to write; sampled on handshake.
WR_DATA  in  DATA_WIDTH  data to write; sampled on handshake.
WWL  out  2**ADDR_WIDTH  one-hot write word lines, active-high.
WBL  out  DATA_WIDTH  write bit lines to the array.
WR_DONE  out  1  one-cycle pulse when the write has completed.
BUSY  out  1  high whenever state is not IDLE.

Behaviour:
- Interface: one clock CLK; reset RST_N is synchronous and active-low.
- Reset (RST_N=0 sampled at a rising edge):
  - state goes to IDLE;
  - WWL=0, WBL=0, WR_DONE=0, BUSY=0, WR_READY=1;
  - address/data registers and pulse counter clear to 0.
- Reset mid-operation aborts the write. WWL is 0 from the next edge, and no WR_DONE is produced.
- All outputs are registered or decoded from registered state only. There is no combinational path from inputs to outputs; WR_READY is a function of state alone.
- FSM states:
  - IDLE:
    - WR_READY=1.
    - On WR_VALID=1 at an edge: capture WR_ADDR and WR_DATA, then go to SETUP.
    - Otherwise stay in IDLE.
  - SETUP (1 cycle):
    - WBL = captured data; WWL=0; WR_READY=0.
    - Load the pulse counter with PULSE_CYCLES-1, then go to PULSE.
  - PULSE:
    - WWL = one-hot decode of the captured address (bit addr=1, all other bits 0); WBL is held.
    - While counter != 0: decrement and stay.
    - When counter == 0: go to HOLD.
  - HOLD (1 cycle):
    - WWL=0; WBL still held; WR_DONE=1.
    - Next state is IDLE.
- Latency:
  - handshake edge to first WWL-high cycle = 2 cycles;
  - handshake to WR_DONE = PULSE_CYCLES+2 cycles;
  - minimum interval between accepted requests = PULSE_CYCLES+3 cycles.
- WBL keeps the last written data while in IDLE. Word lines are never asserted without stable bit lines on both sides of the pulse.
- WWL invariants:
  - at most one bit set in every cycle;
  - outside PULSE it is all zeros.
- WR_VALID while WR_READY=0 is ignored and no request is queued. The requester must hold the request until the handshake.
- Changes to WR_ADDR/WR_DATA after the handshake have no effect on the write in progress.
- Every ADDR_WIDTH-bit address is legal because the row count is a power of two: addr 0 drives WWL[0], addr 2**ADDR_WIDTH-1 drives the MSB.

Decomposition:
- Shared package (memory-wide, also used by the read side):
  - state encoding for IDLE/SETUP/PULSE/HOLD;
  - default ADDR_WIDTH and DATA_WIDTH;
  - an N_ROWS = 2**ADDR_WIDTH constant.
- One natural sub-module: wwl_decoder, a combinational ADDR_WIDTH-to-one-hot decoder with an enable input.
  - enable=0 forces all-zero output;
  - the same decoder can later be shared with the read word-line path.

Test Plan:
- Reset check: hold RST_N=0 for 2 cycles, then release -> WR_READY=1, WWL=8'h00, WBL=8'h00, WR_DONE=0, BUSY=0.
- Basic write, PULSE_CYCLES=1: handshake with addr=3'd0, data=8'hA5 ->
  - edge+1: WBL=8'hA5, WWL=0;
  - edge+2: WWL=8'b0000_0001;
  - edge+3: WWL=0, WR_DONE=1;
  - edge+4: WR_READY=1.
- Top row and long pulse, PULSE_CYCLES=3: addr=3'd7, data=8'h3C -> WWL=8'b1000_0000 for exactly 3 cycles, then WR_DONE 1 cycle later.
- Back-to-back with WR_VALID held high, two requests (addr 6 / 8'h41, then addr 1 / 8'h92):
  - second handshake occurs exactly 4 cycles after the first;
  - WWL sequence 8'b0100_0000 then 8'b0000_0010;
  - WBL never changes while either WWL is high.
- Input change after handshake: change WR_ADDR/WR_DATA during SETUP and PULSE -> the original row and data are still written.
- Mid-pulse reset: assert RST_N=0 during PULSE -> next edge WWL=0, WBL=0, no WR_DONE, WR_READY=1 after release.

Source files
------------

// File: rtl/wwl_ctrl_pkg.sv
// Memory-wide definitions shared by the write and read word-line paths of the
// latch-based standard-cell array.
package wwl_ctrl_pkg;

    localparam int DEF_ADDR_WIDTH = 3;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int N_ROWS         = 2 ** DEF_ADDR_WIDTH;

    // Width of the pulse counter; it holds PULSE_CYCLES-1, so at most 14.
    localparam int PULSE_CNT_W    = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_PULSE = 2'd2,
        ST_HOLD  = 2'd3
    } wl_state_e;

endpackage

// File: rtl/wwl_ctrl_decoder.sv
// Address to one-hot word-line decoder with a global enable; intended to be
// shared by both the write and the read word-line drivers.
module wwl_decoder
    import wwl_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic [ADDR_WIDTH-1:0]      addr,
    input  logic                       en,
    output logic [2**ADDR_WIDTH-1:0]   wl
);

    localparam int ROWS = 2 ** ADDR_WIDTH;

    generate
        for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
            assign wl[gi] = en && (addr == ADDR_WIDTH'(gi));
        end
    endgenerate

endmodule

// File: rtl/wwl_ctrl.sv
// Write word-line controller: accepts one write, then sequences bit-line setup,
// a PULSE_CYCLES-long one-hot word-line pulse, and a bit-line hold cycle.
module wwl_ctrl
    import wwl_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int PULSE_CYCLES = 1
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic                       WR_VALID,
    output logic                       WR_READY,
    input  logic [ADDR_WIDTH-1:0]      WR_ADDR,
    input  logic [DATA_WIDTH-1:0]      WR_DATA,
    output logic [2**ADDR_WIDTH-1:0]   WWL,
    output logic [DATA_WIDTH-1:0]      WBL,
    output logic                       WR_DONE,
    output logic                       BUSY
);

    localparam logic [PULSE_CNT_W-1:0] CNT_LOAD = PULSE_CNT_W'(PULSE_CYCLES - 1);

    wl_state_e               state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q,  addr_d;
    logic [DATA_WIDTH-1:0]   data_q,  data_d;
    logic [PULSE_CNT_W-1:0]  cnt_q,   cnt_d;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (WR_VALID) begin
                    addr_d  = WR_ADDR;
                    data_d  = WR_DATA;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                cnt_d   = CNT_LOAD;
                state_d = ST_PULSE;
            end
            ST_PULSE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - PULSE_CNT_W'(1);
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    // The data register only reloads on a handshake, so driving the bit lines
    // straight from it keeps them stable through setup, pulse, hold and idle.
    assign WBL      = data_q;
    assign WR_READY = (state_q == ST_IDLE);
    assign BUSY     = (state_q != ST_IDLE);
    assign WR_DONE  = (state_q == ST_HOLD);

    wwl_decoder #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_decoder (
        .addr (addr_q),
        .en   (state_q == ST_PULSE),
        .wl   (WWL)
    );

endmodule

// File: tb/tb_wwl_ctrl.sv
// Scoreboard bench for wwl_ctrl: two instances (PULSE_CYCLES 1 and 3) driven
// with directed and random writes, compared cycle by cycle to a timeline model.
module tb_wwl_ctrl;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;
    bit lane_done [2];

    typedef struct {
        int         hs;
        logic [2:0] a;
        logic [7:0] d;
    } txn_t;

    task automatic chk(input string name, input int lane,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL lane%0d %s actual=%h required=%h cycle=%0d",
                     lane, name, act, exp, cyc);
        end
    endtask

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lane
            localparam int P = (gi == 0) ? 1 : 3;

            logic       rst_n = 1'b0;
            logic       valid = 1'b0;
            logic [2:0] addr  = '0;
            logic [7:0] data  = '0;
            logic       ready, done, busy;
            logic [7:0] wwl, wbl;

            wwl_ctrl #(
                .ADDR_WIDTH   (3),
                .DATA_WIDTH   (8),
                .PULSE_CYCLES (P)
            ) dut (
                .CLK      (CLK),
                .RST_N    (rst_n),
                .WR_VALID (valid),
                .WR_READY (ready),
                .WR_ADDR  (addr),
                .WR_DATA  (data),
                .WWL      (wwl),
                .WBL      (wbl),
                .WR_DONE  (done),
                .BUSY     (busy)
            );

            txn_t       sb_q [$];
            logic [7:0] last_d = '0;
            bit         armed  = 1'b0;

            // Output monitor: derive the expected outputs for this cycle from
            // the age of the oldest accepted write.
            initial begin : mon
                int         t;
                logic [7:0] e_wwl, e_wbl;
                logic       e_done, e_busy;
                forever begin
                    @(negedge CLK);
                    if (armed) begin
                        while (sb_q.size() > 0 && (cyc - sb_q[0].hs) >= P + 3) begin
                            last_d = sb_q[0].d;
                            void'(sb_q.pop_front());
                        end
                        if (sb_q.size() > 0) begin
                            t      = cyc - sb_q[0].hs;
                            e_wbl  = sb_q[0].d;
                            e_wwl  = (t >= 2 && t <= P + 1) ? (8'd1 << sb_q[0].a) : 8'd0;
                            e_done = (t == P + 2);
                            e_busy = 1'b1;
                        end else begin
                            e_wbl  = last_d;
                            e_wwl  = 8'd0;
                            e_done = 1'b0;
                            e_busy = 1'b0;
                        end
                        chk("wwl",        gi, 32'(wwl),   32'(e_wwl));
                        chk("wbl",        gi, 32'(wbl),   32'(e_wbl));
                        chk("wr_done",    gi, 32'(done),  32'(e_done));
                        chk("busy",       gi, 32'(busy),  32'(e_busy));
                        chk("wr_ready",   gi, 32'(ready), 32'(!e_busy));
                        chk("wwl_onehot", gi, 32'($countones(wwl) <= 1), 32'(1));
                        if (e_done)
                            $display("txn lane%0d P=%0d addr=%0d data=%h accepted@%0d done@%0d wwl=%b wbl=%h",
                                     gi, P, sb_q[0].a, sb_q[0].d, sb_q[0].hs, cyc, wwl, wbl);
                    end
                end
            end

            // Stimulus observer: a request seen while the model is idle will be
            // accepted at the coming edge; a low reset wipes the model.
            initial begin : obs
                forever begin
                    @(negedge CLK);
                    #1;
                    if (rst_n !== 1'b1) begin
                        sb_q.delete();
                        last_d = '0;
                        armed  = 1'b1;
                    end else if (armed && valid && sb_q.size() == 0) begin
                        sb_q.push_back('{hs: cyc, a: addr, d: data});
                    end
                end
            end

            task automatic wait_hs();
                bit got;
                got = 1'b0;
                for (int i = 0; i < 50 && !got; i++) begin
                    @(negedge CLK);
                    if (ready === 1'b1) got = 1'b1;
                end
                chk("handshake_timeout", gi, 32'(got), 32'(1));
                @(posedge CLK);
                #1;
            endtask

            task automatic write(input logic [2:0] a, input logic [7:0] d);
                valid = 1'b1;
                addr  = a;
                data  = d;
                wait_hs();
                valid = 1'b0;
            endtask

            task automatic idle_cycles(input int n);
                repeat (n) @(posedge CLK);
                #1;
            endtask

            initial begin : drv
                idle_cycles(2);
                rst_n = 1'b1;
                idle_cycles(1);

                if (gi == 0) write(3'd0, 8'hA5);
                else         write(3'd7, 8'h3C);
                idle_cycles(P + 4);

                valid = 1'b1;
                addr  = 3'd6;
                data  = 8'h41;
                wait_hs();
                addr  = 3'd1;
                data  = 8'h92;
                wait_hs();
                valid = 1'b0;
                idle_cycles(P + 4);

                write(3'd5, 8'h5A);
                for (int i = 0; i < P + 2; i++) begin
                    addr = 3'($urandom);
                    data = 8'($urandom);
                    idle_cycles(1);
                end
                idle_cycles(2);

                write(3'd2, 8'hC3);
                idle_cycles(1);
                rst_n = 1'b0;
                idle_cycles(1);
                rst_n = 1'b1;
                idle_cycles(3);

                for (int i = 0; i < 400; i++) begin
                    valid = ($urandom_range(0, 2) != 0);
                    addr  = 3'($urandom);
                    data  = 8'($urandom);
                    rst_n = ($urandom_range(0, 79) != 0);
                    idle_cycles(1);
                end
                valid = 1'b0;
                rst_n = 1'b1;
                idle_cycles(P + 6);
                lane_done[gi] = 1'b1;
            end
        end
    endgenerate

    initial begin : fin
        fork
            wait (lane_done[0] && lane_done[1]);
            #100000;
        join_any
        if (!(lane_done[0] && lane_done[1])) begin
            checks++;
            failures++;
            $display("FAIL global_timeout actual=lanes_running required=lanes_done cycle=%0d", cyc);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
